// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int CNT_W_DEFAULT = 32;

    // The nearer stage (M) wins when both M and W hold the operand.
    function automatic logic [1:0] fwd_sel(
        input logic match_m,
        input logic wr_m,
        input logic match_w,
        input logic wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (match_m && wr_m)
            sel = FWD_M;
        else if (match_w && wr_w)
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear.
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding selects, stalls, flushes and
// debug event counters for the 5-stage pipeline.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             BranchTakenE,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] LdStallCnt,
    output logic [CNT_W-1:0] BrFlushCnt,
    output logic [CNT_W-1:0] PcWrFlushCnt
);

    logic reg_write_e, mem_to_reg_e, pc_src_e;
    logic reg_write_m, pc_src_m;
    logic reg_write_w, pc_src_w;
    logic ldr_stall, pc_wr_pend;

    // No stall enable here: a held D instruction enters E as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_e  <= 1'b0;
            mem_to_reg_e <= 1'b0;
            pc_src_e     <= 1'b0;
            reg_write_m  <= 1'b0;
            pc_src_m     <= 1'b0;
            reg_write_w  <= 1'b0;
            pc_src_w     <= 1'b0;
        end else begin
            reg_write_e  <= FlushE ? 1'b0 : RegWriteD;
            mem_to_reg_e <= FlushE ? 1'b0 : MemtoRegD;
            pc_src_e     <= FlushE ? 1'b0 : PCSrcD;
            reg_write_m  <= reg_write_e;
            pc_src_m     <= pc_src_e;
            reg_write_w  <= reg_write_m;
            pc_src_w     <= pc_src_m;
        end
    end

    assign ForwardAE = fwd_sel(Match_1E_M, reg_write_m,
                               Match_1E_W, reg_write_w);
    assign ForwardBE = fwd_sel(Match_2E_M, reg_write_m,
                               Match_2E_W, reg_write_w);

    assign ldr_stall  = Match_12D_E & mem_to_reg_e;
    assign pc_wr_pend = PCSrcD | pc_src_e | pc_src_m;

    assign StallF = ldr_stall | pc_wr_pend;
    assign StallD = ldr_stall;
    assign FlushD = pc_wr_pend | pc_src_w | BranchTakenE;
    assign FlushE = ldr_stall | BranchTakenE;

    hazard_sat_counter #(.W(CNT_W)) u_ld_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (ldr_stall),
        .q     (LdStallCnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (BranchTakenE),
        .q     (BrFlushCnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_pc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (CntClr),
        .inc   (pc_src_w),
        .q     (PcWrFlushCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: per-cycle vector table plus
// hand sequences for saturation, clear and async reset.
module tb_hazard_unit;

    localparam int W = 4;
    localparam int NV = 19;

    logic clk = 1'b0;
    logic reset;
    logic m1m, m1w, m2m, m2w, m12;
    logic rwd, mtrd, pcsd, bte, clr;
    logic [1:0] fa, fb;
    logic stall_f, stall_d, flush_d, flush_e;
    logic [W-1:0] ldc, brc, pcc;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .Match_1E_M   (m1m),
        .Match_1E_W   (m1w),
        .Match_2E_M   (m2m),
        .Match_2E_W   (m2w),
        .Match_12D_E  (m12),
        .RegWriteD    (rwd),
        .MemtoRegD    (mtrd),
        .PCSrcD       (pcsd),
        .BranchTakenE (bte),
        .CntClr       (clr),
        .ForwardAE    (fa),
        .ForwardBE    (fb),
        .StallF       (stall_f),
        .StallD       (stall_d),
        .FlushD       (flush_d),
        .FlushE       (flush_e),
        .LdStallCnt   (ldc),
        .BrFlushCnt   (brc),
        .PcWrFlushCnt (pcc)
    );

    // m = {m1m, m1w, m2m, m2w, m12}; sf = {StallF, StallD, FlushD, FlushE}
    typedef struct {
        logic [4:0] m;
        logic       rwd, mtrd, pcsd, bte;
        logic [1:0] fa, fb;
        logic [3:0] sf;
        logic [3:0] ldc, brc, pcc;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(
        input logic [4:0] m,
        input logic rw, input logic mt, input logic pc, input logic bt,
        input logic [1:0] a, input logic [1:0] b, input logic [3:0] sf,
        input logic [3:0] l, input logic [3:0] r, input logic [3:0] p
    );
        vec_t v;
        v.m = m; v.rwd = rw; v.mtrd = mt; v.pcsd = pc; v.bte = bt;
        v.fa = a; v.fb = b; v.sf = sf;
        v.ldc = l; v.brc = r; v.pcc = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] m, input logic rw,
                         input logic mt, input logic pc, input logic bt,
                         input logic c);
        {m1m, m1w, m2m, m2w, m12} = m;
        rwd = rw; mtrd = mt; pcsd = pc; bte = bt; clr = c;
    endtask

    function automatic logic [3:0] sf_now();
        return {stall_f, stall_d, flush_d, flush_e};
    endfunction

    initial begin
        vt[0]  = mk(5'b00000, 1,0,0,0, 2'b00,2'b00, 4'b0000, 0,0,0);
        vt[1]  = mk(5'b11000, 1,0,0,0, 2'b00,2'b00, 4'b0000, 0,0,0);
        vt[2]  = mk(5'b11010, 0,0,0,0, 2'b10,2'b00, 4'b0000, 0,0,0);
        vt[3]  = mk(5'b11010, 0,0,0,0, 2'b10,2'b01, 4'b0000, 0,0,0);
        vt[4]  = mk(5'b01100, 0,0,0,0, 2'b01,2'b00, 4'b0000, 0,0,0);
        vt[5]  = mk(5'b11110, 0,0,0,0, 2'b00,2'b00, 4'b0000, 0,0,0);
        vt[6]  = mk(5'b00001, 1,1,0,0, 2'b00,2'b00, 4'b0000, 0,0,0);
        vt[7]  = mk(5'b00001, 0,0,0,0, 2'b00,2'b00, 4'b1101, 0,0,0);
        vt[8]  = mk(5'b00001, 0,0,0,0, 2'b00,2'b00, 4'b0000, 1,0,0);
        vt[9]  = mk(5'b00000, 0,0,0,0, 2'b00,2'b00, 4'b0000, 1,0,0);
        vt[10] = mk(5'b00000, 0,0,1,0, 2'b00,2'b00, 4'b1010, 1,0,0);
        vt[11] = mk(5'b00000, 0,0,0,0, 2'b00,2'b00, 4'b1010, 1,0,0);
        vt[12] = mk(5'b00000, 0,0,0,0, 2'b00,2'b00, 4'b1010, 1,0,0);
        vt[13] = mk(5'b00000, 0,0,0,0, 2'b00,2'b00, 4'b0010, 1,0,0);
        vt[14] = mk(5'b00000, 0,0,0,0, 2'b00,2'b00, 4'b0000, 1,0,1);
        vt[15] = mk(5'b00000, 1,1,0,0, 2'b00,2'b00, 4'b0000, 1,0,1);
        vt[16] = mk(5'b00001, 1,1,0,1, 2'b00,2'b00, 4'b1111, 1,0,1);
        vt[17] = mk(5'b00101, 0,0,0,0, 2'b00,2'b10, 4'b0000, 2,1,1);
        vt[18] = mk(5'b00010, 0,0,0,0, 2'b00,2'b01, 4'b0000, 2,1,1);

        drive(5'b0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk("reset_fa", fa, 0);
        chk("reset_fb", fb, 0);
        chk("reset_sf", sf_now(), 0);
        chk("reset_cnt", {ldc, brc, pcc}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i].m, vt[i].rwd, vt[i].mtrd, vt[i].pcsd, vt[i].bte, 1'b0);
            #1;
            chk($sformatf("v%0d_fa", i), fa, vt[i].fa);
            chk($sformatf("v%0d_fb", i), fb, vt[i].fb);
            chk($sformatf("v%0d_sf", i), sf_now(), vt[i].sf);
            chk($sformatf("v%0d_ldc", i), ldc, vt[i].ldc);
            chk($sformatf("v%0d_brc", i), brc, vt[i].brc);
            chk($sformatf("v%0d_pcc", i), pcc, vt[i].pcc);
        end

        // Saturation: brc starts at 1, twenty taken branches pin it at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(5'b0, 0, 0, 0, 1, 0);
        end
        @(negedge clk);
        drive(5'b0, 0, 0, 0, 0, 0);
        #1;
        chk("sat_brc", brc, 15);
        @(negedge clk);
        drive(5'b0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("sat_hold", brc, 15);

        // Clear wins over a simultaneous increment, on every counter.
        drive(5'b0, 0, 0, 0, 1, 1);
        @(negedge clk);
        drive(5'b0, 0, 0, 0, 0, 0);
        #1;
        chk("clr_brc", brc, 0);
        chk("clr_ldc", ldc, 0);
        chk("clr_pcc", pcc, 0);

        // Load counters, then start an R15 write and reset it mid-flight.
        drive(5'b0, 0, 0, 0, 1, 0);
        @(negedge clk);
        drive(5'b0, 0, 0, 1, 0, 0);
        #1;
        chk("pre_brc", brc, 1);
        @(negedge clk);
        drive(5'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("pcm_stallf", stall_f, 1);
        chk("pcm_flushd", flush_d, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_stallf", stall_f, 0);
        chk("arst_flushd", flush_d, 0);
        chk("arst_cnt", {ldc, brc, pcc}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst_sf", sf_now(), 0);
            chk("post_rst_pcc", pcc, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
